// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control decoder.
// Holds the main FSM state enum, mux-select codes and the FSM control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Moore outputs of the main FSM, consumed by the top-level decode logic.
    typedef struct packed {
        logic       next_pc;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_w;
        logic       mem_w;
        logic       alu_op;
        logic       branch;
    } fsm_ctrl_t;

endpackage

// File: rtl/mc_decoder_if.sv
// Instruction-field inputs and control outputs of the multicycle decoder.
// The state field is a debug view of the main FSM.
interface mc_decoder_if;
    import mc_pkg::*;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NextPC;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    state_t     state;

    modport master (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state
    );

    modport slave (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state
    );

endinterface

// File: rtl/mc_main_fsm.sv
// Main Moore FSM of the multicycle controller: state register, next-state
// logic and per-state datapath controls including ALUOp and Branch.
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       is_imm,
    input  logic       is_load,
    output state_t     state,
    output fsm_ctrl_t  ctrl
);

    state_t next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next = state;
        ctrl = '0;
        case (state)
            S_FETCH: begin
                next            = S_DECODE;
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                case (op)
                    OP_MEM:  next = S_MEMADR;
                    OP_DP:   next = is_imm ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next = S_BRANCH;
                    default: next = S_UNKNOWN;
                endcase
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                next           = is_load ? S_MEMREAD : S_MEMWRITE;
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                next            = S_MEMWB;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                next            = S_FETCH;
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                next         = S_FETCH;
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            S_EXECUTER: begin
                next           = S_ALUWB;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = 1'b1;
            end
            S_EXECUTEI: begin
                next           = S_ALUWB;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                next            = S_FETCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                next            = S_FETCH;
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
            // Undefined opcode parks here until reset; unused encodings recover.
            S_UNKNOWN: next = S_UNKNOWN;
            default:   next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle ARM control decoder: main FSM plus ALU decode, PC-write request
// and immediate/register-source selects derived from the latched fields.
module mc_decoder
    import mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mc_decoder_if.slave  bus
);

    state_t    state;
    fsm_ctrl_t ctrl;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       in_unknown;

    mc_main_fsm u_fsm (
        .clk     (clk),
        .reset   (reset),
        .op      (bus.Op),
        .is_imm  (bus.Funct[5]),
        .is_load (bus.Funct[0]),
        .state   (state),
        .ctrl    (ctrl)
    );

    // Unrecognised Funct codes fall back to ADD with no flag writes.
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (ctrl.alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin alu_control = ALU_ADD; flag_w = {2{bus.Funct[0]}};    end
                4'b0010: begin alu_control = ALU_SUB; flag_w = {2{bus.Funct[0]}};    end
                4'b0000: begin alu_control = ALU_AND; flag_w = {bus.Funct[0], 1'b0}; end
                4'b1100: begin alu_control = ALU_ORR; flag_w = {bus.Funct[0], 1'b0}; end
                default: begin alu_control = ALU_ADD; flag_w = 2'b00;                end
            endcase
        end
    end

    assign in_unknown = (state == S_UNKNOWN);

    assign bus.PCS        = ctrl.branch | (ctrl.reg_w & (bus.Rd == 4'hF));
    assign bus.RegW       = ctrl.reg_w;
    assign bus.MemW       = ctrl.mem_w;
    assign bus.FlagW      = flag_w;
    assign bus.NextPC     = ctrl.next_pc;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.AdrSrc     = ctrl.adr_src;
    assign bus.ResultSrc  = ctrl.result_src;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUControl = alu_control;
    // Field-derived selects are silenced too so UNKNOWN drives nothing.
    assign bus.ImmSrc     = in_unknown ? 2'b00 : bus.Op;
    assign bus.RegSrc     = in_unknown ? 2'b00 : {bus.Op == OP_MEM, bus.Op == OP_BR};
    assign bus.state      = state;

endmodule

// File: tb/tb_mc_decoder.sv
// Bench for mc_decoder: directed and random instructions expand into the
// expected per-cycle control vectors, which a negedge monitor compares.
module tb_mc_decoder;

    logic clk;
    logic reset;
    logic mon_en;
    int   tests;
    int   fails;
    logic [19:0] exp_q[$];

    mc_decoder_if bus ();

    mc_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [19:0] vec(
        input logic pcs, input logic regw, input logic memw, input logic [1:0] flagw,
        input logic nextpc, input logic irwrite, input logic adrsrc,
        input logic [1:0] ressrc, input logic [1:0] srca, input logic [1:0] srcb,
        input logic [1:0] aluctl, input logic [1:0] imm, input logic [1:0] regsrc);
        return {pcs, regw, memw, flagw, nextpc, irwrite, adrsrc,
                ressrc, srca, srcb, aluctl, imm, regsrc};
    endfunction

    function automatic logic [1:0] reg_src(input logic [1:0] op);
        return {op == 2'b01, op == 2'b10};
    endfunction

    function automatic logic [19:0] fetch_row(input logic [1:0] op);
        return vec(0, 0, 0, 2'b00, 1, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00, op, reg_src(op));
    endfunction

    function automatic logic [19:0] actual();
        return {bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.NextPC, bus.IRWrite,
                bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.ImmSrc, bus.RegSrc};
    endfunction

    // Opcode table: ADD/SUB update all flags with S, AND/ORR only NZ.
    task automatic alu_model(input logic [5:0] f, output logic [1:0] ctl, output logic [1:0] fw);
        int code;
        code = int'(f[4:1]);
        ctl = 2'b00;
        fw  = 2'b00;
        if (code == 4)       begin ctl = 2'b00; fw = {f[0], f[0]}; end
        else if (code == 2)  begin ctl = 2'b01; fw = {f[0], f[0]}; end
        else if (code == 0)  begin ctl = 2'b10; fw = {f[0], 1'b0}; end
        else if (code == 12) begin ctl = 2'b11; fw = {f[0], 1'b0}; end
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %05h expected %05h", name, $time, act, exp);
        end
    endtask

    // Push one row per cycle the instruction should spend, FETCH to FETCH.
    task automatic build_rows(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                              output int n);
        logic [1:0] r;
        logic [1:0] ctl;
        logic [1:0] fw;
        logic       pcw;
        r   = reg_src(op);
        pcw = (rd == 4'hF);
        exp_q.push_back(fetch_row(op));
        exp_q.push_back(vec(0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, op, r));
        n = 2;
        if (op == 2'b01) begin
            exp_q.push_back(vec(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, op, r));
            if (f[0]) begin
                exp_q.push_back(vec(0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, r));
                exp_q.push_back(vec(pcw, 1, 0, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, op, r));
                n = 5;
            end else begin
                exp_q.push_back(vec(0, 0, 1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, r));
                n = 4;
            end
        end else if (op == 2'b00) begin
            alu_model(f, ctl, fw);
            exp_q.push_back(vec(0, 0, 0, fw, 0, 0, 0, 2'b00, 2'b00,
                                f[5] ? 2'b01 : 2'b00, ctl, op, r));
            exp_q.push_back(vec(pcw, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, op, r));
            n = 4;
        end else begin
            exp_q.push_back(vec(1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, op, r));
            n = 3;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic release_reset();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        int n;
        bus.Op    = op;
        bus.Funct = f;
        bus.Rd    = rd;
        build_rows(op, f, rd, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_unknown(input int hold);
        bus.Op    = 2'b11;
        bus.Funct = 6'($urandom_range(0, 63));
        bus.Rd    = 4'($urandom_range(0, 15));
        exp_q.push_back(fetch_row(2'b11));
        exp_q.push_back(vec(0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00));
        for (int i = 0; i < hold; i++) exp_q.push_back(20'h0);
        repeat (hold + 2) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cycle at %0t: got %05h expected none", $time, actual());
            end else begin
                check("cycle_outputs", actual(), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] codes [4];
        int n;
        codes[0] = 4'b0100; codes[1] = 4'b0010; codes[2] = 4'b0000; codes[3] = 4'b1100;
        tests     = 0;
        fails     = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        bus.Op    = 2'b00;
        bus.Funct = 6'd0;
        bus.Rd    = 4'd0;
        #2;
        check("reset_outputs", actual(), fetch_row(2'b00));
        release_reset();

        run_instr(2'b01, 6'b011001, 4'd2);   // LDR
        run_instr(2'b01, 6'b011000, 4'd3);   // STR
        run_instr(2'b00, 6'b000101, 4'd1);   // SUBS reg
        run_instr(2'b00, 6'b001000, 4'd4);   // ADD imm
        run_instr(2'b00, 6'b011001, 4'd5);   // ORRS
        run_instr(2'b00, 6'b001000, 4'hF);   // ADD to PC
        run_instr(2'b01, 6'b011001, 4'hF);   // LDR to PC
        run_instr(2'b00, 6'b010111, 4'd6);   // undefined Funct
        run_instr(2'b10, 6'b101010, 4'd7);   // B

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 2));
            f  = 6'($urandom_range(0, 63));
            if (op == 2'b00 && $urandom_range(0, 1) == 1) f[4:1] = codes[$urandom_range(0, 3)];
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            run_instr(op, f, rd);
        end

        run_unknown(12);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_exits_unknown", actual(), fetch_row(2'b11));

        // Load interrupted by reset while in MEMREAD, between clock edges.
        release_reset();
        bus.Op    = 2'b01;
        bus.Funct = 6'b011001;
        bus.Rd    = 4'd9;
        build_rows(2'b01, 6'b011001, 4'd9, n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        void'(exp_q.pop_back());
        reset = 1'b1;
        #1;
        check("reset_mid_memread", actual(), fetch_row(2'b01));
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        release_reset();
        run_instr(2'b00, 6'b000101, 4'hF);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_decoder.md
Name: mc_decoder

Overview:
- Control-side producer for the multicycle ARM datapath.
- Decodes the latched instruction fields (Op, Funct, Rd) through a Moore main FSM.
- Drives the unconditional write requests PCS, RegW, MemW and FlagW[1:0], which the conditional-write stage qualifies with the condition result.
- Also drives every datapath mux select and enable for each multicycle step.

Parameters:
- none (ISA-fixed widths)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FSM to FETCH
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- PCS  out  1  PC-write request, subject to condition
- RegW  out  1  register-write request, subject to condition
- MemW  out  1  memory-write request, subject to condition
- FlagW  out  2  [1]=NZ write request, [0]=CV write request
- NextPC  out  1  unconditional PC write (fetch)
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0=PC, 1=ALU result register
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=register A, 01=PC
- ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous, active-high; while asserted, state=FETCH.
- Every output is a combinational function of state, Op, Funct and Rd. No output register.
- Reset output values are the FETCH outputs: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=00, RegW=MemW=PCS=0, FlagW=00.
- State register, 4 bits. States and transitions:
  - FETCH -> DECODE
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN
  - MEMADR: Funct[0]=1 -> MEMREAD, else -> MEMWRITE
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; ALUWB -> FETCH
  - BRANCH -> FETCH
  - UNKNOWN -> UNKNOWN; only reset exits. All outputs are inactive in UNKNOWN.
- Moore outputs per state (unlisted outputs are 0):
  - FETCH: as the reset values above.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1: Funct[4:1] selects 0100 ADD=00, 0010 SUB=01, 0000 AND=10, 1100 ORR=11. Any other value gives ALUControl=00 and FlagW=00, never X.
  - FlagW[1] = Funct[0] when ALUOp=1.
  - FlagW[0] = Funct[0] & (ADD|SUB) when ALUOp=1.
- PCS = Branch | (RegW & Rd==4'hF). PC-writing loads and ALU ops therefore assert PCS only in MEMWB/ALUWB.
- Latency: load 5 cycles, store 4, data-processing 4, branch 3, all counted from FETCH to FETCH.
- Reset asserted mid-instruction: state is FETCH immediately, without waiting for a clock edge. No partial RegW or MemW pulse survives.

Decomposition:
- Package mc_pkg holds:
  - state_t enum (11 states, 4-bit encoding)
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR
  - Op constants OP_DP, OP_MEM, OP_BR
  - mux-select constants for ResultSrc, ALUSrcA, ALUSrcB
- Sub-module mc_main_fsm holds the state register, next-state logic and Moore outputs, including ALUOp and Branch.
- The ALU decode, PCS, ImmSrc and RegSrc logic stays in mc_decoder.

Test Plan:
- LDR (Op=01, Funct=011001, Rd=2) after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegW=1 only in MEMWB; MemW never asserted.
- STR (Op=01, Funct=011000) -> MEMWRITE on cycle 4 with MemW=1, AdrSrc=1; back to FETCH on cycle 5; RegW=0 throughout.
- SUBS register form (Op=00, Funct=000101) -> EXECUTER with ALUControl=01, FlagW=11; ALUWB RegW=1; ADD without S (Funct=001000, immediate form) -> EXECUTEI, ALUControl=00, FlagW=00.
- ORRS (Funct=011001, Op=00) -> FlagW=10; Rd=15 on ADD -> PCS=1 in ALUWB only.
- Branch (Op=10) -> BRANCH state with PCS=1, ALUSrcB=01, ResultSrc=10; RegSrc=01, ImmSrc=10; FETCH next.
- Op=11 -> UNKNOWN held 10+ cycles with all outputs 0. Reset asserted mid-MEMREAD with no clock edge -> outputs equal FETCH values immediately.
